usr_param_shift: RTL and testbench
==================================

// Module: usr_param_shift
// PURPOSE
//  Parametrised universal shift register, successor to the 4-bit opcode-driven USR.
//  Adds: WIDTH-wide datapath; 8 ops (hold/shift/rotate/arith/load/clear); separate L/R serial ins/outs;
//  multi-cycle burst shifts (amt bits, 1 bit/clk) with busy/done handshake.
//  Used as a serialiser/deserialiser and bit-manipulation stage between datapath regs.
// PARAMETERS
//  WIDTH  8  register width in bits (>=2)
//  CNT_W  $clog2(WIDTH+1)  width of amt (localparam, derived; not overridable)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-low reset
//  en        in   1      command strobe, sampled on clk rise
//  op        in   3      command opcode (usr_op_e)
//  amt       in   CNT_W  burst shift count for SHR/SHL/ROTR/ROTL/ASR
//  pin       in   WIDTH  parallel load data
//  ser_in_r  in   1      serial in, enters MSB on SHR
//  ser_in_l  in   1      serial in, enters LSB on SHL
//  q         out  WIDTH  register contents
//  ser_out_r out  1      registered bit last shifted/rotated out of LSB
//  ser_out_l out  1      registered bit last shifted/rotated out of MSB
//  busy      out  1      high while a burst shift is in progress (state==SHIFT)
//  done      out  1      one-cycle pulse, cycle after the last step of any accepted non-HOLD cmd
// BEHAVIOUR
//  Reset (rst=0, async): q=0, ser_out_r=0, ser_out_l=0, busy=0, done=0, state=IDLE, remaining=0.
//  Opcodes: 0 HOLD, 1 SHR, 2 SHL, 3 LOAD, 4 ROTR, 5 ROTL, 6 ASR, 7 CLEAR.
//  Step rules:
//   SHR  q<={ser_in_r,q[W-1:1]}, ser_out_r<=q[0]
//   SHL  q<={q[W-2:0],ser_in_l}, ser_out_l<=q[W-1]
//   ROTR q<={q[0],q[W-1:1]}, ser_out_r<=q[0]
//   ROTL q<={q[W-2:0],q[W-1]}, ser_out_l<=q[W-1]
//   ASR  q<={q[W-1],q[W-1:1]}, ser_out_r<=q[0]
//  Serial ins are sampled fresh every step cycle. Unaffected ser_out_* hold their value.
//  FSM states: IDLE, SHIFT. Commands are accepted only in IDLE.
//   en=1 during SHIFT is ignored; no error flag; op is latched at acceptance.
//  IDLE, en=0, or en=1 with HOLD: no change, no done.
//  IDLE, en=1, LOAD: q<=pin; done=1 next cycle. CLEAR: q<=0, ser_outs unchanged; done=1 next cycle.
//  IDLE, en=1, shift op:
//   amt=0: no step; done=1 next cycle.
//   amt=1: one step at this edge; stay IDLE; done=1 next cycle.
//   amt=N>1: step at this edge; remaining<=N-1; ->SHIFT.
//  SHIFT: one step per edge, remaining-=1; on the edge where remaining==1, ->IDLE and done<=1.
//  Latency: burst of N occupies N edges; busy is high for N-1 cycles; done is in the cycle after the Nth step.
//  amt>WIDTH is legal and fully executed (e.g. ROTR by WIDTH returns the original q).
//  done and a newly accepted cmd may coincide: a cmd in the done cycle is accepted (state is IDLE).
//  Reset asserted mid-burst: immediate return to reset values; the burst is abandoned, no done.
// CONFIGURATION
//  USR_PARITY_EN defined: extra output port par (1b) = registered ^q.
//   par updates on the same edge as q (par<=^q_next); par reset value 0.
//  USR_PARITY_EN undefined: par port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package usr_pkg: typedef enum logic[2:0] usr_op_e (the 8 opcodes above);
//   typedef enum logic usr_state_e {IDLE,SHIFT}.
//  Sub-module usr_shift_step (combinational, WIDTH param).
//   Inputs: op, q, ser_in_r, ser_in_l. Outputs: q_nxt, out_r, out_l, out_r_vld, out_l_vld.
//   Top holds the FSM, counter and registers.
// TESTING (WIDTH=8)
//  1. Reset then LOAD pin=8'hA5 -> q=A5 next edge, done pulse 1 cycle later, busy never high.
//  2. q=A5, SHR amt=3, ser_in_r=1 -> busy high for 2 cycles, q=F4, ser_out_r=1, single done pulse.
//  3. q=81, ROTL amt=8 -> q=81 after 8 steps, ser_out_l=1.
//     ASR amt=2 on q=80 -> q=E0.
//  4. en=1 with LOAD during a SHL amt=4 burst -> ignored; q reflects only the 4 shifts.
//  5. rst=0 on the 2nd cycle of a SHR amt=5 burst -> q=0, busy=0, done=0 immediately; no done after release.
//  6. SHL amt=0 -> q unchanged, done pulses.
//     USR_PARITY_EN build: LOAD 8'h07 -> par=1; CLEAR -> par=0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the parametrised universal shift register: opcodes, FSM states
// and a small opcode classifier.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_SHR   = 3'd1,
        OP_SHL   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_ROTR  = 3'd4,
        OP_ROTL  = 3'd5,
        OP_ASR   = 3'd6,
        OP_CLEAR = 3'd7
    } usr_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_e;

    // Ops that take the burst path (amt steps, one bit per clock).
    function automatic logic is_shift_op(input usr_op_e op);
        logic r;
        case (op)
            OP_SHR, OP_SHL, OP_ROTR, OP_ROTL, OP_ASR: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of the universal shift register: next contents plus
// the bit leaving each end and whether that end's serial output should take it.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  usr_op_e          op,
    input  logic [WIDTH-1:0] q,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q_nxt,
    output logic             out_r,
    output logic             out_l,
    output logic             out_r_vld,
    output logic             out_l_vld
);

    assign out_r = q[0];
    assign out_l = q[WIDTH-1];

    // Select the one-step transform; non-shift ops leave q untouched.
    always_comb begin
        q_nxt     = q;
        out_r_vld = 1'b0;
        out_l_vld = 1'b0;
        case (op)
            OP_SHR: begin
                q_nxt     = {ser_in_r, q[WIDTH-1:1]};
                out_r_vld = 1'b1;
            end
            OP_SHL: begin
                q_nxt     = {q[WIDTH-2:0], ser_in_l};
                out_l_vld = 1'b1;
            end
            OP_ROTR: begin
                q_nxt     = {q[0], q[WIDTH-1:1]};
                out_r_vld = 1'b1;
            end
            OP_ROTL: begin
                q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
                out_l_vld = 1'b1;
            end
            OP_ASR: begin
                q_nxt     = {q[WIDTH-1], q[WIDTH-1:1]};
                out_r_vld = 1'b1;
            end
            default: begin
                q_nxt     = q;
                out_r_vld = 1'b0;
                out_l_vld = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/usr_param_shift.sv
// Parametrised universal shift register with multi-cycle burst shifts and busy/done
// handshake. Optional registered parity output enabled by USR_PARITY_EN.
module usr_param_shift
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] pin,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             par
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    usr_op_e          op_s;
    usr_op_e          step_op_s;
    logic             take_step_s;
    logic [WIDTH-1:0] step_q_s;
    logic             step_out_r_s;
    logic             step_out_l_s;
    logic             step_out_r_vld_s;
    logic             step_out_l_vld_s;

    usr_state_e       state_q,   state_d;
    usr_op_e          op_q,      op_d;
    logic [CNT_W-1:0] rem_q,     rem_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic             sor_q,     sor_d;
    logic             sol_q,     sol_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    assign op_s = usr_op_e'(op);

    // First step of a burst uses the live opcode; later steps use the latched one.
    always_comb begin
        if (state_q == IDLE) begin
            step_op_s = op_s;
        end else begin
            step_op_s = op_q;
        end
    end

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .op        (step_op_s),
        .q         (q_q),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .q_nxt     (step_q_s),
        .out_r     (step_out_r_s),
        .out_l     (step_out_l_s),
        .out_r_vld (step_out_r_vld_s),
        .out_l_vld (step_out_l_vld_s)
    );

    // Command acceptance, burst sequencing and next-state register values.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        q_d         = q_q;
        sor_d       = sor_q;
        sol_d       = sol_q;
        done_d      = 1'b0;
        take_step_s = 1'b0;

        if (state_q == IDLE) begin
            if (en) begin
                case (op_s)
                    OP_HOLD: begin
                        done_d = 1'b0;
                    end
                    OP_LOAD: begin
                        q_d    = pin;
                        done_d = 1'b1;
                    end
                    OP_CLEAR: begin
                        q_d    = {WIDTH{1'b0}};
                        done_d = 1'b1;
                    end
                    default: begin
                        if (amt == CNT_ZERO) begin
                            done_d = 1'b1;
                        end else if (amt == CNT_ONE) begin
                            take_step_s = 1'b1;
                            done_d      = 1'b1;
                        end else begin
                            take_step_s = 1'b1;
                            rem_d       = amt - CNT_ONE;
                            op_d        = op_s;
                            state_d     = SHIFT;
                        end
                    end
                endcase
            end else begin
                done_d = 1'b0;
            end
        end else begin
            // Commands arriving mid-burst are dropped without any indication.
            take_step_s = 1'b1;
            rem_d       = rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                done_d  = 1'b0;
            end
        end

        if (take_step_s && is_shift_op(step_op_s)) begin
            q_d = step_q_s;
            if (step_out_r_vld_s) begin
                sor_d = step_out_r_s;
            end else begin
                sor_d = sor_q;
            end
            if (step_out_l_vld_s) begin
                sol_d = step_out_l_s;
            end else begin
                sol_d = sol_q;
            end
        end else begin
            take_step_s = 1'b0;
        end

        busy_d = (state_d == SHIFT);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            rem_q   <= CNT_ZERO;
            q_q     <= {WIDTH{1'b0}};
            sor_q   <= 1'b0;
            sol_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            sor_q   <= sor_d;
            sol_q   <= sol_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q         = q_q;
    assign ser_out_r = sor_q;
    assign ser_out_l = sol_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef USR_PARITY_EN
    logic par_q;

    function automatic logic calc_par(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Parity tracks q on the same edge, so it is taken from the next value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= calc_par(q_d);
        end
    end

    assign par = par_q;
`endif

endmodule

// File: tb/tb_usr_param_shift.sv
// Self-checking bench for usr_param_shift (WIDTH=8): directed scenarios plus a
// randomized command stream compared every cycle against a behavioural model.
module tb_usr_param_shift;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] amt = 4'd0;
    logic [7:0] pin = 8'd0;
    logic       ser_in_r = 1'b0;
    logic       ser_in_l = 1'b0;
    logic [7:0] q;
    logic       ser_out_r, ser_out_l, busy, done;
`ifdef USR_PARITY_EN
    logic       par;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    usr_param_shift #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .amt       (amt),
        .pin       (pin),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .q         (q),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
`ifdef USR_PARITY_EN
        ,
        .par       (par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: register value, serial outs, steps still owed by a burst.
    logic [7:0] m_q;
    logic       m_sor, m_sol, m_done;
    int         m_left;
    logic [2:0] m_op;

    task automatic model_reset();
        m_q = 8'h00; m_sor = 1'b0; m_sol = 1'b0; m_done = 1'b0; m_left = 0; m_op = 3'd0;
    endtask

    task automatic model_step(input logic [2:0] o);
        case (o)
            3'd1: begin m_sor = m_q[0]; m_q = (m_q >> 1) | (8'(ser_in_r) << 7); end
            3'd2: begin m_sol = m_q[7]; m_q = 8'((m_q << 1) | 8'(ser_in_l)); end
            3'd4: begin m_sor = m_q[0]; m_q = (m_q >> 1) | (8'(m_q[0]) << 7); end
            3'd5: begin m_sol = m_q[7]; m_q = 8'((m_q << 1) | (m_q >> 7)); end
            3'd6: begin m_sor = m_q[0]; m_q = (m_q >> 1) | (m_q & 8'h80); end
            default: ;
        endcase
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        if (!rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                model_step(m_op);
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (en) begin
                case (op)
                    3'd0: ;
                    3'd3: begin m_q = pin; m_done = 1'b1; end
                    3'd7: begin m_q = 8'h00; m_done = 1'b1; end
                    default: begin
                        m_op = op;
                        if (amt == 4'd0) begin
                            m_done = 1'b1;
                        end else begin
                            model_step(op);
                            m_left = int'(amt) - 1;
                            if (m_left == 0) m_done = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("q", q, m_q);
            check("ser_out_r", ser_out_r, m_sor);
            check("ser_out_l", ser_out_l, m_sol);
            check("busy", busy, m_left > 0);
            check("done", done, m_done);
`ifdef USR_PARITY_EN
            check("par", par, ^m_q);
`endif
        end
    end

    task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] p,
                         input logic sr, input logic sl);
        @(negedge clk);
        en = 1'b1; op = o; amt = a; pin = p; ser_in_r = sr; ser_in_l = sl;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit got);
        bc = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) bc++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int bc;
        bit got;
        int done_seen;

        repeat (2) @(negedge clk);
        check("rst_q", q, 8'h00);
        check("rst_sor", ser_out_r, 1'b0);
        check("rst_sol", ser_out_l, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;
        chk_en = 1'b1;

        // LOAD: q and done together, no busy.
        issue(3'd3, 4'd0, 8'hA5, 1'b0, 1'b0);
        check("t1_q", q, 8'hA5);
        check("t1_done", done, 1'b1);
        check("t1_busy", busy, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", done, 1'b0);

        // SHR by 3 with ones shifted in.
        issue(3'd1, 4'd3, 8'h00, 1'b1, 1'b0);
        wait_done(bc, got);
        check("t2_done_seen", got, 1'b1);
        check("t2_busy_cycles", bc, 2);
        check("t2_q", q, 8'hF4);
        check("t2_model_q", m_q, 8'hF4);
        check("t2_sor", ser_out_r, 1'b1);
        @(negedge clk);
        check("t2_done_pulse", done, 1'b0);

        // ROTL by full width, then ASR by 2.
        issue(3'd3, 4'd0, 8'h81, 1'b0, 1'b0);
        issue(3'd5, 4'd8, 8'h00, 1'b0, 1'b0);
        wait_done(bc, got);
        check("t3_done_seen", got, 1'b1);
        check("t3_busy_cycles", bc, 7);
        check("t3_q", q, 8'h81);
        check("t3_sol", ser_out_l, 1'b1);
        issue(3'd3, 4'd0, 8'h80, 1'b0, 1'b0);
        issue(3'd6, 4'd2, 8'h00, 1'b0, 1'b0);
        wait_done(bc, got);
        check("t3_asr_q", q, 8'hE0);
        check("t3_asr_model_q", m_q, 8'hE0);

        // LOAD during a SHL burst must be ignored.
        issue(3'd3, 4'd0, 8'h0F, 1'b0, 1'b0);
        issue(3'd2, 4'd4, 8'h00, 1'b0, 1'b0);
        en = 1'b1; op = 3'd3; pin = 8'hFF;
        @(negedge clk);
        en = 1'b0;
        wait_done(bc, got);
        check("t4_done_seen", got, 1'b1);
        check("t4_q", q, 8'hF0);
        check("t4_model_q", m_q, 8'hF0);

        // Reset during the second cycle of a burst.
        issue(3'd3, 4'd0, 8'hFF, 1'b0, 1'b0);
        issue(3'd1, 4'd5, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_q", q, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("t5_no_done_after", done_seen, 0);

        // Zero-length shift still pulses done.
        issue(3'd3, 4'd0, 8'h3C, 1'b0, 1'b0);
        issue(3'd2, 4'd0, 8'h00, 1'b0, 1'b1);
        check("t6_done", done, 1'b1);
        check("t6_q", q, 8'h3C);
        check("t6_busy", busy, 1'b0);

`ifdef USR_PARITY_EN
        issue(3'd3, 4'd0, 8'h07, 1'b0, 1'b0);
        check("par_load07", par, 1'b1);
        issue(3'd7, 4'd0, 8'h00, 1'b0, 1'b0);
        check("par_clear", par, 1'b0);
`endif

        // Randomized stream: commands mid-burst, back-to-back, rare resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 1) == 1);
            op       = 3'($urandom_range(0, 7));
            amt      = 4'($urandom_range(0, 15));
            pin      = 8'($urandom);
            ser_in_r = 1'($urandom);
            ser_in_l = 1'($urandom);
            rst      = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
